// File: rtl/nn_input_framer.sv
// Sample framer for the neural-network controller. It conditions raw sensor samples,
// queues them in a FIFO and strobes them out one at a time, FRAME_LEN samples per frame.
module nn_input_framer #(
  parameter int DIN_W     = 12,
  parameter int OFFSET    = 2048,
  parameter int SHIFT     = 3,
  parameter int FRAME_LEN = 1000,
  parameter int DEPTH     = 64,
  parameter int HOLD      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic [DIN_W-1:0] s_data,
  input  logic             nn_done,
  output logic             input_signal,
  output logic [15:0]      nn_in,
  output logic             frame_active,
  output logic             overflow,
  output logic [15:0]      drop_count,
  output logic [7:0]       frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, WAIT_DONE} state_t;

  state_t          state, state_next;
  logic [HW-1:0]   hold_cnt, hold_next;
  logic [CW-1:0]   sample_cnt, sample_next;
  logic [7:0]      frames_next;
  logic            active_next;

  logic signed [31:0] diff, scaled;
  logic [15:0]        cond;

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;

  // DC removal and scaling, saturated into signed 16-bit
  always_comb begin
    diff   = $signed({{(32-DIN_W){1'b0}}, s_data}) - OFFSET;
    scaled = diff <<< SHIFT;
    if (scaled > 32767)       cond = 16'h7FFF;
    else if (scaled < -32768) cond = 16'h8000;
    else                      cond = scaled[15:0];
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = (state == LOAD) && !empty;
  assign push  = s_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cond;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (s_valid && !push) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    sample_next = sample_cnt;
    frames_next = frame_count;
    active_next = frame_active;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next  = LOAD;
          active_next = 1'b1;
        end
      end
      LOAD: begin
        if (!empty) begin
          state_next = HIGH;
          hold_next  = '0;
        end
      end
      HIGH: begin
        if (hold_cnt == HW'(HOLD - 1)) begin
          state_next = LOW;
          hold_next  = '0;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      LOW: begin
        if (hold_cnt == HW'(HOLD - 1)) begin
          hold_next = '0;
          if (sample_cnt == CW'(FRAME_LEN - 1)) begin
            sample_next = '0;
            frames_next = frame_count + 1'b1;
            state_next  = WAIT_DONE;
          end else begin
            sample_next = sample_cnt + 1'b1;
            state_next  = LOAD;
          end
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (nn_done) begin
          active_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // input_signal decodes the next state so the strobe comes straight from a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      sample_cnt   <= '0;
      frame_count  <= '0;
      frame_active <= 1'b0;
      input_signal <= 1'b0;
      nn_in        <= '0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      sample_cnt   <= sample_next;
      frame_count  <= frames_next;
      frame_active <= active_next;
      input_signal <= (state_next == HIGH);
      if (pop) nn_in <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_nn_input_framer.sv
// Directed bench for nn_input_framer: conditioning table, strobe timing, frame hold-off,
// overflow, input stall and mid-frame reset, with a scoreboard on every rising strobe.
module tb_nn_input_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [11:0] s_data;
  logic        nn_done;

  logic        input_signal, frame_active, overflow;
  logic [15:0] nn_in, drop_count;
  logic [7:0]  frame_count;

  logic        sat_input_signal, sat_frame_active, sat_overflow;
  logic [15:0] sat_nn_in, sat_drop_count;
  logic [7:0]  sat_frame_count;

  int checks   = 0;
  int failures = 0;
  int rise_cnt = 0;
  bit sb_en    = 1'b0;
  bit prev_is  = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] last_val;

  typedef struct {
    logic [11:0] raw;
    logic [15:0] exp_main;
    logic [15:0] exp_sat;
  } vec_t;
  vec_t vecs[4];

  nn_input_framer u_dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .nn_done(nn_done),
    .input_signal(input_signal), .nn_in(nn_in), .frame_active(frame_active),
    .overflow(overflow), .drop_count(drop_count), .frame_count(frame_count)
  );

  nn_input_framer #(.SHIFT(5)) u_sat (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .nn_done(nn_done),
    .input_signal(sat_input_signal), .nn_in(sat_nn_in), .frame_active(sat_frame_active),
    .overflow(sat_overflow), .drop_count(sat_drop_count), .frame_count(sat_frame_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] model(int raw, int sh);
    int d;
    d = (raw - 2048) * (1 << sh);
    if (d > 32767)  return 16'h7FFF;
    if (d < -32768) return 16'h8000;
    return d[15:0];
  endfunction

  function automatic logic [11:0] sample_at(int i, int base);
    int v;
    v = (i * 37 + base * 101) % 4096;
    return v[11:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every rising strobe must present the next expected sample
  always @(negedge clk) begin
    if (input_signal && !prev_is) begin
      rise_cnt++;
      if (sb_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got %0h expected no sample", nn_in);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (nn_in !== e) begin
            failures++;
            $display("FAIL sb_data: got %0h expected %0h", nn_in, e);
          end
        end
      end
    end
    prev_is = input_signal;
  end

  // driver tasks (all start and end on a falling edge)
  task automatic do_reset();
    s_valid = 1'b0;
    nn_done = 1'b0;
    reset   = 1'b1;
    #1;
    check("rst_input_signal", 32'(input_signal), 0);
    check("rst_nn_in",        32'(nn_in), 0);
    check("rst_frame_active", 32'(frame_active), 0);
    check("rst_overflow",     32'(overflow), 0);
    check("rst_drop_count",   32'(drop_count), 0);
    check("rst_frame_count",  32'(frame_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rise_cnt = 0;
  endtask

  task automatic push(input logic [11:0] v, input bit store);
    s_valid = 1'b1;
    s_data  = v;
    if (store) begin
      last_val = model(int'(v), 3);
      if (sb_en) exp_q.push_back(last_val);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic run_samples(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      push(sample_at(i, base), 1'b1);
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic pulse_done();
    nn_done = 1'b1;
    @(negedge clk);
    nn_done = 1'b0;
  endtask

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (input_signal) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    bit exp_is[1:6];
    logic [15:0] held;

    vecs[0] = '{12'd2048, 16'h0000, 16'h0000};
    vecs[1] = '{12'd2049, 16'h0008, 16'h0020};
    vecs[2] = '{12'd0,    16'hC000, 16'h8000};
    vecs[3] = '{12'd4095, 16'h3FF8, 16'h7FFF};
    exp_is  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b0; s_valid = 1'b0; s_data = '0; nn_done = 1'b0;
    @(negedge clk);
    do_reset();

    // conditioning table, both shift settings
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].raw, 1'b0);
      wait_rise(ok);
      check($sformatf("cond_rise_%0d", i), 32'(ok), 1);
      check($sformatf("cond_main_%0d", i), 32'(nn_in), 32'(vecs[i].exp_main));
      check($sformatf("cond_sat_%0d", i), 32'(sat_nn_in), 32'(vecs[i].exp_sat));
      repeat (8) @(negedge clk);
    end

    // strobe timing for one sample into an idle block
    do_reset();
    push(12'h900, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("strobe_is_t%0d", k), 32'(input_signal), 32'(exp_is[k]));
      if (k >= 2 && k <= 5) check($sformatf("strobe_nn_t%0d", k), 32'(nn_in), 32'h0800);
      if (k == 1) check("strobe_active", 32'(frame_active), 1);
    end

    // full frame with an early nn_done that must be ignored
    do_reset();
    sb_en = 1'b1;
    run_samples(500, 1);
    pulse_done();
    for (int i = 500; i < 1000; i++) begin
      push(sample_at(i, 1), 1'b1);
      repeat (4) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("frame_rises", 32'(rise_cnt), 1000);
    check("frame_count_1", 32'(frame_count), 1);
    check("frame_active_wait", 32'(frame_active), 1);
    check("frame_is_low", 32'(input_signal), 0);

    // overflow while held in WAIT_DONE
    for (int i = 0; i < 70; i++) push(sample_at(i, 2), i < 64);
    repeat (20) @(negedge clk);
    check("ovf_hold_rises", 32'(rise_cnt), 1000);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_drops", 32'(drop_count), 6);
    pulse_done();
    repeat (350) @(negedge clk);
    check("ovf_drain_rises", 32'(rise_cnt), 1064);
    check("ovf_drain_empty", 32'(exp_q.size()), 0);

    // 20-cycle input gap mid-frame: stalled in LOAD with outputs held
    held = last_val;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (input_signal !== 1'b0 || nn_in !== held) ok = 1'b0;
    end
    check("stall_hold", 32'(ok), 1);
    check("stall_nn_in", 32'(nn_in), 32'(held));
    run_samples(5, 3);
    repeat (20) @(negedge clk);
    check("stall_resume_rises", 32'(rise_cnt), 1069);
    check("stall_resume_empty", 32'(exp_q.size()), 0);
    check("stall_frame_count", 32'(frame_count), 1);

    // reset mid-frame with samples still queued
    do_reset();
    sb_en = 1'b1;
    run_samples(497, 5);
    for (int i = 0; i < 3; i++) push(sample_at(i, 6), 1'b1);
    do_reset();
    repeat (15) @(negedge clk);
    check("mrst_no_stale", 32'(rise_cnt), 0);
    check("mrst_active", 32'(frame_active), 0);
    run_samples(999, 7);
    repeat (20) @(negedge clk);
    check("mrst_rises_999", 32'(rise_cnt), 999);
    check("mrst_fc_999", 32'(frame_count), 0);
    check("mrst_active_999", 32'(frame_active), 1);
    push(12'h123, 1'b1);
    repeat (20) @(negedge clk);
    check("mrst_rises_1000", 32'(rise_cnt), 1000);
    check("mrst_fc_1000", 32'(frame_count), 1);
    check("mrst_is_low", 32'(input_signal), 0);
    check("mrst_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_input_framer.md
Name: nn_input_framer

Overview:
- Upstream feeder for the neural-network controller.
- Conditions raw texture-sensor samples into signed 16-bit fixed point and buffers them in a FIFO.
- Presents samples one at a time using the controller's strobe protocol: `nn_in` stable while `input_signal` pulses high then low.
- Delivers exactly FRAME_LEN samples per frame, then holds off until the controller signals classification done.

Parameters:
- DIN_W, 12: raw sample width, unsigned.
- OFFSET, 2048: value subtracted from each raw sample (DC removal).
- SHIFT, 3: left shift applied after offset removal.
- FRAME_LEN, 1000: samples per frame.
- DEPTH, 64: FIFO depth; power of 2, minimum 4.
- HOLD, 2: cycles `input_signal` stays high, and cycles it stays low, per sample; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- s_valid  in  1  raw sample strobe, one sample per cycle when high; no backpressure.
- s_data  in  DIN_W  raw unsigned sample.
- nn_done  in  1  single-cycle pulse from the controller: classification of the current frame complete.
- input_signal  out  1  sample strobe to the controller.
- nn_in  out  16  conditioned sample to the controller.
- frame_active  out  1  high from the first LOAD of a frame until nn_done is accepted.
- overflow  out  1  sticky; set on any dropped sample.
- drop_count  out  16  dropped samples, saturates at 65535.
- frame_count  out  8  completed frames, wraps at 256.

Behaviour:
- Reset: every output is 0, FIFO empty, FSM in IDLE, sample counter 0. Applies immediately, including mid-frame; a partial frame is discarded.
- Conditioning (combinational, before FIFO write):
  - d = s_data zero-extended, minus OFFSET, signed; then d <<< SHIFT.
  - Saturate to [-32768, 32767].
  - The conditioned 16-bit value is what gets stored.
- FIFO write:
  - On s_valid, write if not full, or if full and a pop occurs the same cycle.
  - Otherwise drop: set overflow, increment drop_count (saturating).
  - A write at cycle t is readable at t+1 (first-word fall-through, registered array).
- FIFO read: pop only in LOAD with FIFO non-empty.
- FSM states: IDLE, LOAD, HIGH, LOW, WAIT_DONE.
  - IDLE: if FIFO non-empty, go to LOAD and set frame_active=1.
  - LOAD: if FIFO non-empty, pop, register the head into nn_in, go to HIGH. If empty, stay in LOAD (stall); input_signal stays 0 and nn_in holds.
  - HIGH: input_signal=1 for HOLD cycles, then go to LOW.
  - LOW: input_signal=0 for HOLD cycles. Then increment the sample counter. If the counter reaches FRAME_LEN, reset it to 0, increment frame_count, go to WAIT_DONE; otherwise go to LOAD.
  - WAIT_DONE: input_signal=0. On nn_done, clear frame_active and go to IDLE. FIFO keeps accepting samples in this state.
- input_signal is registered and glitch-free. nn_in changes only on LOAD exit, so it is stable throughout HIGH and LOW.
- Per-sample period with no stall: 1 + 2*HOLD cycles; 5 cycles at default.
- First-sample latency: s_valid at t (FSM idle) gives LOAD at t+1, nn_in valid at t+2, input_signal rises at t+2.
- nn_done outside WAIT_DONE is ignored; it is not remembered.
- Sample counter width: ceil(log2(FRAME_LEN+1)).
- FIFO pointers: log2(DEPTH)+1 bits; full/empty by MSB compare. Simultaneous push and pop when empty is not possible, because a pop requires non-empty.

Test Plan:
- Conditioning: s_data=2048 gives nn_in=0; 2049 gives 8; 0 gives -16384 (0xC000); 4095 gives 16376. Also with SHIFT=5, 4095 gives +32767 (saturated) and 0 gives -32768.
- Strobe protocol, HOLD=2: single sample 0x900 into an idle block. Expect input_signal high on exactly cycles t+2..t+3 and low t+4..t+5, with nn_in=0x0800 stable t+2..t+5.
- Full frame: feed 1000 samples at 1 per 5 cycles. Expect exactly 1000 input_signal rising edges, frame_count=1, then WAIT_DONE with input_signal=0. Sample 1001 does not appear until nn_done is pulsed; nn_done pulsed earlier mid-frame has no effect.
- Overflow: DEPTH=64, hold FSM in WAIT_DONE, push 70 samples. Expect overflow=1, drop_count=6. After nn_done, the first 64 samples are emitted in order.
- Stall: gap of 20 cycles in the input stream mid-frame. Expect the FSM to stay in LOAD with input_signal=0 and nn_in held, then resume with no lost or duplicated samples.
- Reset mid-frame at sample 500: all outputs 0 and FIFO empty. The next frame starts from the sample counter at 0 and needs 1000 fresh samples.
